uart_tx_stream: RTL
===================

UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 Parameter: c_BAUD_DIV, default 434, clocks per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Port: clk  input  1  single clock for all logic.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: s_data  input  8  byte from the upstream prefetch FIFO (its rd_data).
REQ-005 Port: s_vld  input  1  byte available (FIFO rd_vld).
REQ-006 Port: s_rdy  output  1  block accepts a byte this cycle (drives FIFO rd_en).
REQ-007 Port: txd  output  1  serial line, idle high.
REQ-008 Port: busy  output  1  frame in progress.
REQ-009 Port: frame_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-010 The block SHALL transfer a byte only on a clock edge where s_vld=1 and s_rdy=1 (pop); s_rdy SHALL NOT depend combinationally on s_vld or s_data.
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY (parity build only), and STOP; s_rdy=1 exactly in IDLE, and busy=1 in every other state.
REQ-012 On pop in IDLE, the block SHALL latch s_data into a shift register, clear the baud counter, enter START, and drive txd=0 from the next cycle (1-cycle latency).
REQ-013 Each bit state SHALL last exactly c_BAUD_DIV clocks, counted 0..c_BAUD_DIV-1 by a baud counter that wraps to 0 at each bit boundary.
REQ-014 DATA SHALL send bits 0..7 LSB first, using a 3-bit index that advances on each bit boundary; leaving DATA on index 7 SHALL go to PARITY if it is compiled in, otherwise to STOP.
REQ-015 txd SHALL be registered (no combinational path from state to pin): txd=0 in START, data bit in DATA, parity bit in PARITY, and 1 in STOP and IDLE.
REQ-016 At the last clock of STOP, frame_done SHALL pulse for one cycle and the FSM SHALL return to IDLE.
REQ-017 Back-to-back bytes SHALL be separated by exactly 1 extra idle-high clock, the IDLE cycle in which the next pop occurs.
REQ-018 s_vld=0 in IDLE SHALL hold the block in IDLE with txd=1 indefinitely; s_vld and s_data SHALL be ignored while busy=1.
REQ-019 Frame length from first START clock to last STOP clock SHALL be 10*c_BAUD_DIV clocks, or 11*c_BAUD_DIV with parity.

Reset
REQ-020 While rst_n=0, the block SHALL hold state=IDLE, txd=1, busy=0, frame_done=0, baud counter=0, bit index=0, and shift register=0; the resulting s_rdy value of 1 SHALL cause no transfer while rst_n=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately (txd=1 asynchronously) and discard the byte; the first pop is permitted on the first clock after release.

Configuration
REQ-022 Macro UART_TX_PARITY_EN: when defined, the PARITY state SHALL be compiled in and SHALL send even parity (XOR of the 8 data bits) for c_BAUD_DIV clocks between DATA and STOP.
REQ-023 When UART_TX_PARITY_EN is undefined, no parity logic SHALL exist and frames SHALL be 8N1.

Verification (c_BAUD_DIV=4)
REQ-024 s_data=0xA5 with s_vld pulsed in IDLE -> txd per 4-clock bit 0,1,0,1,0,0,1,0,1,1; frame_done pulses at clock 40 after pop; s_rdy=0 for clocks 1..40.
REQ-025 UART_TX_PARITY_EN defined, s_data=0xA5 then 0x01 -> parity bit 0 for the first frame and 1 for the second; each frame is 44 clocks.
REQ-026 s_vld held high with the FIFO preloaded with 0x55,0xAA,0xFF -> three pops spaced exactly 41 clocks apart; the bytes are received in order.
REQ-027 rst_n driven low at clock 13 of a 0x00 frame -> txd=1 in the same cycle, busy=0; after release, the next byte 0x3C is sent complete and correct.
REQ-028 s_vld toggling randomly while busy=1 -> zero pops until busy falls; no byte is lost or duplicated against a FIFO scoreboard over 1000 bytes.

Source files
------------

// File: rtl/uart_tx_stream.sv
// rtl/uart_tx_stream.sv - UART transmitter popping bytes from a valid/ready stream, 8N1 by default
// Define UART_TX_PARITY_EN to insert an even parity bit between data and stop (8E1).
module uart_tx_stream #(
    parameter int c_BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_vld,
    output logic       s_rdy,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] c_CNT_LAST = 16'(c_BAUD_DIV - 1);
    localparam logic [15:0] c_CNT_DONE = 16'(c_BAUD_DIV - 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_shift;
    logic        r_txd;
    logic        r_busy;
    logic        r_done;
    logic        w_bit_end;

    assign w_bit_end  = (r_cnt == c_CNT_LAST);
    assign s_rdy      = ~r_busy;
    assign txd        = r_txd;
    assign busy       = r_busy;
    assign frame_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_txd   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // Set one clock early so the registered pulse lands on the last STOP clock.
            r_done <= (r_state == STOP) && (r_cnt == c_CNT_DONE);

            if (r_state == IDLE || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            case (r_state)
                IDLE: begin
                    if (s_vld) begin
                        r_shift <= s_data;
                        r_idx   <= '0;
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_txd   <= r_shift[0];
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_txd   <= ^r_shift;
                            r_state <= PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_txd <= r_shift[r_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_txd   <= 1'b1;
                        r_state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
